pipe_mem_arbiter: RTL and testbench
===================================

Name: pipe_mem_arbiter

Overview:
- Shares one single-port, fixed-latency 64-bit memory between two requesters of the 5-stage pipeline: the IF-stage instruction fetch and the MEM-stage load/store.
- Data accesses have priority. A starvation counter guarantees that fetch makes forward progress.
- The pipeline stalls any stage whose request is pending (req high, ready not yet pulsed). This block only sequences the memory and returns data; the pipeline generates the stalls.

Parameters:
- MEM_LAT, 2, cycles from mem_en high to mem_rdata valid (legal 1..15).
- STARVE_MAX, 4, consecutive data grants taken while if_req was pending before fetch is forced to win (legal 1..15).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_ready is sampled.
- if_addr  in  64  fetch byte address.
- if_rdata  out  32  fetched instruction: mem_rdata[63:32] if if_addr[2] else [31:0].
- if_ready  out  1  one-cycle pulse; fetch complete, if_rdata valid.
- d_req  in  1  data request; d_we/d_addr/d_wdata held until d_ready.
- d_we  in  1  1=store, 0=load.
- d_addr  in  64  data byte address.
- d_wdata  in  64  store data.
- d_rdata  out  64  load data.
- d_ready  out  1  one-cycle pulse; data access complete.
- mem_en  out  1  memory command strobe, exactly one cycle per access.
- mem_we  out  1  write enable, valid with mem_en.
- mem_addr  out  64  latched address with bits [2:0] forced to 0.
- mem_wdata  out  64  latched store data.
- mem_rdata  in  64  memory read data, valid exactly MEM_LAT cycles after the mem_en cycle.
- gnt_d  out  1  owner of the current or last access (1=data, 0=fetch).

Behaviour:
- Reset (asynchronous, effective immediately):
  - state=IDLE; starve_cnt=0.
  - All outputs are 0, including if_rdata, d_rdata and gnt_d.
  - An in-flight access is abandoned with no ready pulse. A write already strobed may have completed in memory.
- All outputs are registered.
- State IDLE (cycle T): if d_req or if_req is sampled high, pick a winner.
  - Fetch wins if if_req && (!d_req || starve_cnt==STARVE_MAX).
  - Otherwise data wins.
  - Latch the winner's address, we (fetch uses we=0), wdata and addr[2]. Go to ISSUE.
- State ISSUE (cycle T+1):
  - mem_en=1, mem_we, mem_addr and mem_wdata driven from the latch; gnt_d set.
  - Load wait counter with MEM_LAT. Go to WAIT.
- State WAIT: counter decrements each cycle.
  - In cycle T+1+MEM_LAT, capture mem_rdata; for stores the capture is discarded. Go to RESP.
- State RESP (cycle T+2+MEM_LAT):
  - Pulse the winner's ready for exactly one cycle.
  - Load: d_rdata is updated.
  - Fetch: if_rdata is updated with the half selected by the latched addr[2].
  - Store: d_rdata is unchanged.
  - Requests are ignored in RESP. Next state is IDLE.
- Latency: request sampled in cycle T gives ready in cycle T+2+MEM_LAT. Minimum spacing between accesses is MEM_LAT+3 cycles.
- Outside ISSUE: mem_en=0. mem_we, mem_addr and mem_wdata hold their last values.
- if_rdata and d_rdata hold until the next completion of their own type.
- starve_cnt (4-bit, saturating at STARVE_MAX):
  - Increments on a data grant while if_req is high.
  - Clears to 0 on any fetch grant.
  - Unchanged on a data grant with if_req low.
- A request dropped before IDLE samples it is never issued.
- A request dropped mid-access still completes; its ready pulse is harmless.
- Illegal input combinations have no detection; behaviour for them is undefined.

Test Plan:
- Reset values: assert reset mid-run → all outputs 0 within the same cycle. After release, no ready pulse until a new request.
- Single fetch (MEM_LAT=2):
  - Stimulus: if_req=1, if_addr=0x4 sampled at cycle 0; mem_rdata=0xAAAABBBBCCCCDDDD in cycle 3.
  - Response: mem_en=1 and mem_addr=0x0 in cycle 1; if_ready=1 and if_rdata=0xAAAABBBB in cycle 4; gnt_d=0.
- Store:
  - Stimulus: d_req=1, d_we=1, d_addr=0x1D, d_wdata=0x1234.
  - Response: single mem_en cycle with mem_we=1, mem_addr=0x18, mem_wdata=0x1234; d_ready 3 cycles later; d_rdata unchanged.
- Priority and starvation (STARVE_MAX=4): if_req and d_req held high continuously → grants in order D,D,D,D,F,D,D,D,D,F. if_ready fires on the 5th completion, and starve_cnt returns to 0 after each fetch grant.
- Load after fetch: d_req load at 0x40 with mem_rdata=0x0123456789ABCDEF → d_ready with d_rdata=0x0123456789ABCDEF. if_rdata keeps its previous value.
- Reset mid-access: reset asserted in the WAIT cycle following mem_en → no if_ready/d_ready pulse. A fresh if_req after release completes normally with MEM_LAT+2 latency.

Source files
------------

// File: rtl/pipe_mem_arbiter_if.sv
// pipe_mem_arbiter_if: fetch/data request-ready pairs plus the shared memory command/response bus
// Ports: master = pipeline and memory side, slave = arbiter side.
interface pipe_mem_arbiter_if;
  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [63:0] d_rdata;
  logic        d_ready;
  logic        mem_en;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        gnt_d;
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata, gnt_d
  );
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata, gnt_d
  );
endinterface

// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: shares one fixed-latency 64-bit memory between IF fetch and MEM load/store
// Ports: CLK, reset (async, active-high); bus (slave) carries both request/ready pairs,
// the registered memory command (mem_en/we/addr/wdata), mem_rdata and the gnt_d owner flag.
module pipe_mem_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic               CLK,
  input logic               reset,
  pipe_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t     state, state_nx;
  logic [3:0] cnt, starve_cnt;
  logic       hi, fetch_win, grant, done, unused_bits;
  assign fetch_win   = bus.if_req && (!bus.d_req || starve_cnt == 4'(STARVE_MAX));
  assign grant       = state == IDLE && (bus.if_req || bus.d_req);
  assign done        = state == WAIT && cnt == 4'd1;
  assign unused_bits = ^{bus.if_addr[1:0], bus.d_addr[2:0]};
  always_comb begin
    state_nx = state;
    state_nx = grant ? ISSUE : state == ISSUE ? WAIT : done ? RESP : state == RESP ? IDLE : state;
  end
  always_ff @(posedge CLK or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // Memory command is latched at the grant edge so it is already registered during ISSUE.
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      cnt           <= '0;
      starve_cnt    <= '0;
      hi            <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.gnt_d     <= 1'b0;
      bus.if_ready  <= 1'b0;
      bus.d_ready   <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rdata   <= '0;
    end else begin
      bus.mem_en   <= grant;
      bus.if_ready <= done && !bus.gnt_d;
      bus.d_ready  <= done && bus.gnt_d;
      if (grant) begin
        bus.gnt_d    <= !fetch_win;
        bus.mem_we   <= !fetch_win && bus.d_we;
        bus.mem_addr <= {fetch_win ? bus.if_addr[63:3] : bus.d_addr[63:3], 3'b000};
        hi           <= bus.if_addr[2];
        starve_cnt   <= fetch_win ? 4'd0 :
                        (bus.if_req && starve_cnt != 4'(STARVE_MAX)) ? starve_cnt + 4'd1 : starve_cnt;
        if (!fetch_win) bus.mem_wdata <= bus.d_wdata;
      end
      if (state == ISSUE) cnt <= 4'(MEM_LAT);
      else if (state == WAIT) cnt <= cnt - 4'd1;
      if (done && !bus.gnt_d) bus.if_rdata <= hi ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
      if (done && bus.gnt_d && !bus.mem_we) bus.d_rdata <= bus.mem_rdata;
    end
endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// tb_pipe_mem_arbiter: randomized and directed checks against a transaction-level arbiter model
module tb_pipe_mem_arbiter;
  localparam int L  = 2;
  localparam int SM = 4;
  logic CLK = 1'b0;
  logic reset = 1'b1;
  pipe_mem_arbiter_if bus();
  pipe_mem_arbiter #(.MEM_LAT(L), .STARVE_MAX(SM)) dut (.CLK(CLK), .reset(reset), .bus(bus.slave));
  always #5 CLK = ~CLK;
  int checks = 0, failures = 0, cyc = 0;
  int en_cyc = -100, rdy_cyc = -100, busy_until = 0, starve = 0;
  logic        e_d = 0, e_we = 0, e_hi = 0, exp_gnt = 0;
  logic [63:0] e_addr = 0, e_wdata = 0, rd_val = 0, exp_d = 0;
  logic [31:0] exp_if = 0;
  logic        auto_req = 0, keep = 0, record = 0;
  logic        gq[$];
  logic [63:0] mem [logic [63:0]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mem_read(input logic [63:0] a);
    if (!mem.exists(a)) mem[a] = {$urandom, $urandom};
    return mem[a];
  endfunction

  // Model: an access sampled in cycle c strobes memory in c+1, returns in c+2+L, frees IDLE at c+3+L.
  task automatic predict();
    logic f;
    if (reset || cyc < busy_until || !(bus.if_req || bus.d_req)) return;
    f = bus.if_req && (!bus.d_req || starve == SM);
    starve = f ? 0 : bus.if_req ? (starve < SM ? starve + 1 : SM) : starve;
    en_cyc = cyc + 1;
    rdy_cyc = cyc + 2 + L;
    busy_until = cyc + 3 + L;
    e_d = !f;
    e_we = !f && bus.d_we;
    e_addr = (f ? bus.if_addr : bus.d_addr) & ~64'h7;
    e_wdata = bus.d_wdata;
    e_hi = bus.if_addr[2];
  endtask

  task automatic step();
    predict();
    @(negedge CLK);
    cyc++;
    if (cyc == en_cyc) begin
      exp_gnt = e_d;
      if (record) gq.push_back(bus.gnt_d);
      if (e_we) mem[e_addr] = e_wdata;
      else rd_val = mem_read(e_addr);
    end
    if (cyc == rdy_cyc && !e_d) exp_if = e_hi ? rd_val[63:32] : rd_val[31:0];
    if (cyc == rdy_cyc && e_d && !e_we) exp_d = rd_val;
    check("mem_en", 64'(bus.mem_en), 64'(cyc == en_cyc));
    check("if_ready", 64'(bus.if_ready), 64'(cyc == rdy_cyc && !e_d));
    check("d_ready", 64'(bus.d_ready), 64'(cyc == rdy_cyc && e_d));
    check("gnt_d", 64'(bus.gnt_d), 64'(exp_gnt));
    check("if_rdata", 64'(bus.if_rdata), 64'(exp_if));
    check("d_rdata", bus.d_rdata, exp_d);
    if (cyc == en_cyc) begin
      check("mem_addr", bus.mem_addr, e_addr);
      check("mem_we", 64'(bus.mem_we), 64'(e_we));
      if (e_we) check("mem_wdata", bus.mem_wdata, e_wdata);
    end
    bus.mem_rdata = (cyc == en_cyc + L && !e_we) ? rd_val : {$urandom, $urandom};
    if (cyc == rdy_cyc && !keep) begin
      if (e_d) bus.d_req = 1'b0;
      else bus.if_req = 1'b0;
    end
    if (auto_req) begin
      if (!bus.if_req && $urandom_range(3) == 0) begin
        bus.if_req = 1'b1;
        bus.if_addr = 64'($urandom_range(255));
      end
      if (!bus.d_req && $urandom_range(3) == 0) begin
        bus.d_req = 1'b1;
        bus.d_we = 1'($urandom_range(1));
        bus.d_addr = 64'($urandom_range(255));
        bus.d_wdata = {$urandom, $urandom};
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (bus.if_req || bus.d_req); i++) step();
    check("drain_timeout", 64'(bus.if_req || bus.d_req), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 64'({bus.mem_en, bus.mem_we, bus.if_ready, bus.d_ready, bus.gnt_d}), 64'd0);
    check({tag, "_mem_addr"}, bus.mem_addr, 64'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 64'd0);
    check({tag, "_if_rdata"}, 64'(bus.if_rdata), 64'd0);
    check({tag, "_d_rdata"}, bus.d_rdata, 64'd0);
  endtask

  initial begin
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0;
    #7;
    check_zero("reset");
    step(); step();
    reset = 1'b0;
    busy_until = cyc;
    // single fetch of the upper half of word 0
    mem[64'h0] = 64'hAAAABBBBCCCCDDDD;
    bus.if_req = 1'b1; bus.if_addr = 64'h4;
    drain();
    check("fetch_if_rdata", 64'(bus.if_rdata), 64'hAAAABBBB);
    // store to an unaligned address
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 64'h1D; bus.d_wdata = 64'h1234;
    drain();
    check("store_mem", mem[64'h18], 64'h1234);
    // both requesters held: fetch is forced through every STARVE_MAX+1 grants
    bus.if_req = 1'b1; bus.d_req = 1'b1; keep = 1'b1; record = 1'b1;
    for (int i = 0; i < 200 && gq.size() < 10; i++) step();
    keep = 1'b0; record = 1'b0;
    drain();
    check("starve_grants", 64'(gq.size()), 64'd10);
    for (int i = 0; i < 10 && i < gq.size(); i++)
      check($sformatf("starve_gnt%0d", i), 64'(gq[i]), 64'(i % 5 != 4));
    // load after fetch
    mem[64'h40] = 64'h0123456789ABCDEF;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'h40;
    drain();
    check("load_d_rdata", bus.d_rdata, 64'h0123456789ABCDEF);
    check("load_if_kept", 64'(bus.if_rdata), 64'hAAAABBBB);
    // reset in the first WAIT cycle abandons the access
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'h80;
    for (int i = 0; i < 20 && cyc != en_cyc + 1; i++) step();
    check("wait_reached", 64'(cyc == en_cyc + 1), 64'd1);
    #1 reset = 1'b1;
    #1 check_zero("midreset");
    bus.d_req = 1'b0; bus.if_req = 1'b0;
    en_cyc = -100; rdy_cyc = -100; starve = 0;
    exp_gnt = 0; exp_if = 0; exp_d = 0;
    step(); step();
    reset = 1'b0;
    busy_until = cyc;
    repeat (4) step();
    mem[64'h48] = 64'h5555666677778888;
    bus.if_req = 1'b1; bus.if_addr = 64'h4C;
    drain();
    check("post_reset_fetch", 64'(bus.if_rdata), 64'h55556666);
    // randomized traffic
    auto_req = 1'b1;
    repeat (600) step();
    auto_req = 1'b0;
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
